// File: rtl/serial_sat_addsub_if.sv
// Operand/result handshake bundle for the bit-serial saturating add/subtract unit.
interface serial_sat_addsub_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         overflow;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, s, overflow
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, s, overflow
   );
endinterface

// File: rtl/serial_sat_addsub.sv
// Bit-serial signed saturating add/subtract, one full-adder cell, LSB first.
//
// state | meaning
// IDLE  | waiting for operands (in_ready high once out of reset)
// SHIFT | one operand bit per clock through the full adder
// DONE  | saturated result presented until the consumer takes it
module serial_sat_addsub #(
   parameter int W = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   serial_sat_addsub_if.slave  bus,
   output logic                busy_o
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state_q, state_d;
   logic           in_ready_q;
   logic [W-1:0]   opa_q;
   logic [W-1:0]   opb_q;
   logic           carry_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   s_q;
   logic           ovf_q;

   logic           accept;
   logic           last_bit;
   logic           sum_bit;
   logic           carry_out;
   logic [W-1:0]   raw;
   logic           ovf_d;
   logic [W-1:0]   sat;
   logic           out_valid;

   assign accept   = (state_q == IDLE) && in_ready_q && bus.in_valid;
   assign last_bit = (cnt_q == CW'(W - 1));

   // Full-adder cell plus the saturation decode used on the final bit.
   // The sum bits are shifted into the top of opA as its own bits drain out
   // of the bottom, so opA doubles as the result shift register.
   always_comb begin
      sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
      carry_out = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
      raw       = {sum_bit, opa_q[W-1:1]};
      ovf_d     = carry_q ^ carry_out;
      sat       = raw;
      if (ovf_d) begin
         sat = raw[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
      end
   end

   // State register; in_ready is registered from the next state so it stays
   // low through reset and carries no path from the inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == IDLE);
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      out_valid = (state_q == DONE);
      busy_o    = (state_q != IDLE);
   end

   // Operand capture, serial datapath and registered result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  opa_q   <= bus.a;
                  opb_q   <= bus.mode ? bus.b : ~bus.b;
                  carry_q <= ~bus.mode;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               opa_q   <= raw;
               opb_q   <= opb_q >> 1;
               carry_q <= carry_out;
               cnt_q   <= cnt_q + CW'(1);
               if (last_bit) begin
                  s_q   <= sat;
                  ovf_q <= ovf_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.s         = s_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_sat_addsub.sv
// Directed and exhaustive checks of the bit-serial saturating add/subtract unit.
module tb_serial_sat_addsub;
   localparam int W = 4;

   logic clk;
   logic rst;
   logic busy;
   int   n_chk;
   int   n_err;
   int   cyc;
   int   last_acc;

   serial_sat_addsub_if #(.W(W)) bif ();

   serial_sat_addsub #(.W(W)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bif),
      .busy_o (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Independent reference: true signed result clamped to the W-bit range.
   task automatic ref_model(input logic [3:0] av, input logic [3:0] bv, input logic m,
                            output logic [3:0] es, output logic eo);
      int ia, ib, r;
      ia = $signed(av);
      ib = $signed(bv);
      r  = m ? ia + ib : ia - ib;
      eo = 1'b0;
      if (r > 7) begin
         r  = 7;
         eo = 1'b1;
      end else if (r < -8) begin
         r  = -8;
         eo = 1'b1;
      end
      es = r[3:0];
   endtask

   task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic m);
      int n;
      n = 0;
      @(negedge clk);
      bif.out_ready = 1'b0;
      while (!bif.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", {31'b0, bif.in_ready}, 32'd1);
      bif.in_valid = 1'b1;
      bif.a        = av;
      bif.b        = bv;
      bif.mode     = m;
      @(posedge clk);
      #1;
      if (last_acc >= 0) chk("init_interval_ge6", {31'b0, (cyc - last_acc) >= 6}, 32'd1);
      last_acc = cyc;
      chk("busy_at_accept", {31'b0, busy}, 32'd1);
      chk("in_ready_at_accept", {31'b0, bif.in_ready}, 32'd0);
      @(negedge clk);
      bif.in_valid = 1'b0;
      bif.a        = ~av;
      bif.b        = ~bv;
      bif.mode     = ~m;
   endtask

   task automatic wait_result(input logic [3:0] es, input logic eo);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bif.out_valid && n < 20);
      chk("latency", n, W);
      chk("s", {28'b0, bif.s}, {28'b0, es});
      chk("overflow", {31'b0, bif.overflow}, {31'b0, eo});
      chk("busy_done", {31'b0, busy}, 32'd1);
   endtask

   task automatic handoff(input int stall);
      repeat (stall) begin
         @(negedge clk);
         bif.out_ready = 1'b0;
         @(posedge clk);
         #1;
         chk("hold_out_valid", {31'b0, bif.out_valid}, 32'd1);
      end
      @(negedge clk);
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("handoff_out_valid", {31'b0, bif.out_valid}, 32'd0);
      chk("handoff_in_ready", {31'b0, bif.in_ready}, 32'd1);
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       m;
      logic [3:0] s;
      logic       o;
   } vec_t;

   vec_t dir[9] = '{
      '{4'h3, 4'h2, 1'b1, 4'h5, 1'b0},
      '{4'h5, 4'h4, 1'b1, 4'h7, 1'b1},
      '{4'h8, 4'hF, 1'b1, 4'h8, 1'b1},
      '{4'h7, 4'h8, 1'b1, 4'hF, 1'b0},
      '{4'h2, 4'h5, 1'b0, 4'hD, 1'b0},
      '{4'h8, 4'h1, 1'b0, 4'h8, 1'b1},
      '{4'h7, 4'hF, 1'b0, 4'h7, 1'b1},
      '{4'h0, 4'h8, 1'b0, 4'h7, 1'b1},
      '{4'h8, 4'h8, 1'b0, 4'h0, 1'b0}
   };

   initial begin
      logic [3:0] es;
      logic       eo;
      n_chk         = 0;
      n_err         = 0;
      cyc           = 0;
      last_acc      = -100;
      rst           = 1'b1;
      bif.in_valid  = 1'b0;
      bif.a         = '0;
      bif.b         = '0;
      bif.mode      = 1'b0;
      bif.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, bif.in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_s", {28'b0, bif.s}, 32'd0);
      chk("rst_overflow", {31'b0, bif.overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {31'b0, bif.in_ready}, 32'd1);

      foreach (dir[i]) begin
         send(dir[i].a, dir[i].b, dir[i].m);
         wait_result(dir[i].s, dir[i].o);
         handoff(0);
      end

      // Backpressure: result held, new operand pulses ignored.
      send(4'h5, 4'h4, 1'b1);
      wait_result(4'h7, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bif.out_ready = 1'b0;
         bif.in_valid  = 1'b1;
         bif.a         = 4'(k + 1);
         bif.b         = 4'(k + 9);
         bif.mode      = k[0];
         @(posedge clk);
         #1;
         chk("bp_out_valid", {31'b0, bif.out_valid}, 32'd1);
         chk("bp_in_ready", {31'b0, bif.in_ready}, 32'd0);
         chk("bp_s", {28'b0, bif.s}, 32'h7);
         chk("bp_overflow", {31'b0, bif.overflow}, 32'd1);
      end
      @(negedge clk);
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_handoff_valid", {31'b0, bif.out_valid}, 32'd0);
      chk("bp_handoff_in_ready", {31'b0, bif.in_ready}, 32'd1);
      @(negedge clk);
      bif.out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_not_queued", {31'b0, busy}, 32'd0);

      // Reset after two SHIFT cycles abandons the operation.
      send(4'h3, 4'h2, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", {31'b0, bif.out_valid}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_in_ready", {31'b0, bif.in_ready}, 32'd0);
      chk("midrst_s", {28'b0, bif.s}, 32'd0);
      chk("midrst_overflow", {31'b0, bif.overflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_in_ready_after", {31'b0, bif.in_ready}, 32'd1);
      chk("midrst_no_result", {31'b0, bif.out_valid}, 32'd0);
      last_acc = -100;
      send(4'h6, 4'h3, 1'b0);
      wait_result(4'h3, 1'b0);
      handoff(1);

      // Exhaustive back-to-back with random stalls.
      for (int m = 0; m < 2; m++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               ref_model(4'(ia), 4'(ib), m[0], es, eo);
               send(4'(ia), 4'(ib), m[0]);
               wait_result(es, eo);
               handoff($urandom_range(0, 2));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/serial_sat_addsub.md
# serial_sat_addsub

Bit-serial signed saturating add/subtract unit with valid/ready handshakes on both sides. It is the sequential, area-minimal counterpart to the team's combinational saturating adder. Operands are accepted once, processed LSB-first at one bit per clock, and the saturated result plus an overflow flag are presented until the downstream consumer takes them. It sits between an operand producer and a result consumer in the datapath, and trades W+2 cycles of throughput for a single full-adder cell.

## Interface
- W, default 4: operand/result width, two's complement signed; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, mode are valid.
- in_ready  output  1  unit can accept operands (high only in IDLE).
- a  input  W  signed operand A.
- b  input  W  signed operand B.
- mode  input  1  1 = add (a+b), 0 = subtract (a−b).
- out_valid  output  1  s and overflow are valid.
- out_ready  input  1  consumer accepts result.
- s  output  W  saturated signed result.
- overflow  output  1  1 when the true result was outside the signed W-bit range and s was saturated.
- busy  output  1  high in SHIFT or DONE.

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a into opA.
  - latch mode ? b : ~b into opB.
  - set carry = ~mode (this is the +1 of the two's-complement subtraction).
  - clear bit counter and result shift register.
  - go to SHIFT.
- SHIFT: each cycle processes bit i = counter.
  - sum_i = opA[i]^opB[i]^carry.
  - carry ← majority(opA[i], opB[i], carry).
  - sum_i shifts into the result register (LSB first); the counter increments.
  - Record the carry into the MSB when i = W−1.
  - After bit W−1, go to DONE.
- Overflow rule: ovf = carry_into_msb XOR carry_out_of_msb.
  - If ovf and raw MSB = 1 (positive overflow): s = {0, all 1s}, e.g. 0111.
  - If ovf and raw MSB = 0 (negative overflow): s = {1, all 0s}, e.g. 1000.
  - Otherwise s = raw result and overflow = 0.
- s and overflow are registered. They update only on the SHIFT→DONE transition.
- DONE: out_valid=1 and in_ready=0. On out_ready, go to IDLE. In IDLE, s and overflow hold their last value.
- Operand inputs are ignored outside the accepting handshake. Changes on a, b, or mode during SHIFT/DONE have no effect.
- in_valid while in_ready=0 is ignored and not queued.

## Timing
- Reset (rst high at an edge): state=IDLE, s=0, overflow=0, out_valid=0, busy=0, counter=0, carry=0. in_ready=0 while rst is high and 1 from the first cycle after rst deasserts.
- Reset mid-operation (SHIFT or DONE) abandons the operation. No result is produced, and all outputs take their reset values at that edge.
- Latency: accept at edge E0. Bits 0..W−1 are processed at edges E1..EW. out_valid is high after edge EW, i.e. W edges after accept.
- out_valid is held with s and overflow stable until the edge where out_ready=1. out_valid falls at that edge, and in_ready rises in the same cycle.
- Minimum initiation interval is W+2 cycles (accept, W shifts, 1 DONE cycle with out_ready=1). There is no overlap between result hand-off and the next accept.
- out_ready while out_valid=0 has no effect.
- in_ready, out_valid and busy are decoded from state only; there is no combinational path from inputs.

## Test plan
- Add 3+2 (mode=1, W=4) → s=0101, overflow=0. out_valid rises exactly 4 edges after accept. busy is high from accept until hand-off.
- Add saturation:
  - 5+4 → s=0111, overflow=1.
  - −8+−1 (1000+1111) → s=1000, overflow=1.
  - 7+−8 → s=1111, overflow=0.
- Subtract (mode=0):
  - 2−5 → 1101, overflow=0.
  - −8−1 → 1000, overflow=1.
  - 7−(−1) → 0111, overflow=1.
  - 0−(−8) → 0111, overflow=1.
  - −8−(−8) → 0000, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → s and overflow stable, in_ready=0, and in_valid pulses with new operands are ignored. Raising out_ready gives a single hand-off, then in_ready=1 the next cycle.
- Reset after 2 SHIFT cycles → next cycle all outputs at reset values, in_ready=1 after rst drops. A following 6−3 → 0011, overflow=0.
- Exhaustive back-to-back: all 512 (a,b,mode) combinations with random out_ready stalls are checked against a saturating reference model, and the initiation interval is never below 6 cycles.
